// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and its result consumer.
// Ports: req0_*/req1_* operation requests, rsp_* result FIFO head and occupancy.
interface alu_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               req0_vld;
    logic               req0_rdy;
    logic signed [31:0] req0_a;
    logic signed [31:0] req0_b;
    logic [4:0]         req0_shamt;
    logic [2:0]         req0_op;

    logic               req1_vld;
    logic               req1_rdy;
    logic signed [31:0] req1_a;
    logic signed [31:0] req1_b;
    logic [4:0]         req1_shamt;
    logic [2:0]         req1_op;

    logic               rsp_vld;
    logic               rsp_rdy;
    logic [31:0]        rsp_data;
    logic               rsp_id;
    logic [CW-1:0]      rsp_count;

    modport slave (
        input  req0_vld, req0_a, req0_b, req0_shamt, req0_op,
        input  req1_vld, req1_a, req1_b, req1_shamt, req1_op,
        input  rsp_rdy,
        output req0_rdy, req1_rdy,
        output rsp_vld, rsp_data, rsp_id, rsp_count
    );

    modport master (
        output req0_vld, req0_a, req0_b, req0_shamt, req0_op,
        output req1_vld, req1_a, req1_b, req1_shamt, req1_op,
        output rsp_rdy,
        input  req0_rdy, req1_rdy,
        input  rsp_vld, rsp_data, rsp_id, rsp_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter; results queue in a FIFO.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave: requests + responses).
module alu_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [CW-1:0]      count;
    logic               prio;
    logic [32:0]        mem [DEPTH];

    logic               gnt;
    logic               room;
    logic               push;
    logic               pop;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic [4:0]         sh;
    logic [2:0]         op;
    logic [31:0]        res;
    logic [32:0]        head;

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        gnt = bus.req1_vld;
        if (bus.req0_vld && bus.req1_vld) begin
            gnt = prio;
        end
    end

    // Credit is based on occupancy before any pop this cycle.
    assign room = count < FULL;
    assign bus.req0_rdy = rst_n & room & bus.req0_vld & ~gnt;
    assign bus.req1_rdy = rst_n & room & bus.req1_vld & gnt;
    assign push = bus.req0_rdy | bus.req1_rdy;
    assign pop  = bus.rsp_vld & bus.rsp_rdy;

    always_comb begin
        a  = gnt ? bus.req1_a : bus.req0_a;
        b  = gnt ? bus.req1_b : bus.req0_b;
        sh = gnt ? bus.req1_shamt : bus.req0_shamt;
        op = gnt ? bus.req1_op : bus.req0_op;
    end

    // The single shared ALU.
    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a + b;
            3'b011: res = b << sh;
            3'b100: res = b >>> sh;
            3'b101: res = {b[15:0], 16'h0000};
            3'b110: res = a - b;
            3'b111: res = {31'd0, a < b};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            prio  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                prio <= ~gnt;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty-state outputs are forced to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {res, gnt};
        end
    end

    assign head          = mem[rptr];
    assign bus.rsp_vld   = count != '0;
    assign bus.rsp_data  = bus.rsp_vld ? head[32:1] : 32'd0;
    assign bus.rsp_id    = bus.rsp_vld ? head[0] : 1'b0;
    assign bus.rsp_count = count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_arbiter;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    alu_arbiter_if #(.DEPTH(DEPTH)) bus ();

    alu_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic        id;
    } ent_t;

    ent_t q[$];
    logic mprio = 1'b0;
    logic pend_push = 1'b0;
    logic pend_pop = 1'b0;
    ent_t pend_ent;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [4:0] sh);
        longint unsigned p;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: begin
                p = longint'(b) * (64'd1 << sh);
                return p[31:0];
            end
            3'd4: return $signed(b) >>> sh;
            3'd5: return (b & 32'h0000FFFF) * 32'd65536;
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Compare process: outputs are checked mid-cycle, and the model's
    // transfer decisions for the coming edge are recorded.
    always @(negedge clk) begin
        logic pick;
        logic e_r0;
        logic e_r1;
        logic e_vld;
        if (rst_n === 1'b1) begin
            if (bus.req0_vld && bus.req1_vld) pick = mprio;
            else pick = bus.req1_vld;
            e_r0 = bus.req0_vld && !pick && q.size() < DEPTH;
            e_r1 = bus.req1_vld && pick && q.size() < DEPTH;
            e_vld = q.size() != 0;
            chk("m_rdy0", {31'd0, bus.req0_rdy}, {31'd0, e_r0});
            chk("m_rdy1", {31'd0, bus.req1_rdy}, {31'd0, e_r1});
            chk("m_vld", {31'd0, bus.rsp_vld}, {31'd0, e_vld});
            chk("m_data", bus.rsp_data, e_vld ? q[0].d : 32'd0);
            chk("m_id", {31'd0, bus.rsp_id}, {31'd0, e_vld ? q[0].id : 1'b0});
            chk("m_count", 32'(bus.rsp_count), 32'(q.size()));
            pend_push = e_r0 || e_r1;
            pend_pop = e_vld && bus.rsp_rdy;
            if (pick)
                pend_ent.d = ref_alu(bus.req1_op, bus.req1_a, bus.req1_b,
                                     bus.req1_shamt);
            else
                pend_ent.d = ref_alu(bus.req0_op, bus.req0_a, bus.req0_b,
                                     bus.req0_shamt);
            pend_ent.id = pick;
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (pend_pop) void'(q.pop_front());
            if (pend_push) begin
                q.push_back(pend_ent);
                mprio = ~pend_ent.id;
            end
        end
        pend_push = 1'b0;
        pend_pop = 1'b0;
    end

    always @(negedge rst_n) begin
        q.delete();
        mprio = 1'b0;
        pend_push = 1'b0;
        pend_pop = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_vld = 0;
        bus.req1_vld = 0;
        bus.req0_a = 0;
        bus.req0_b = 0;
        bus.req0_shamt = 0;
        bus.req0_op = 0;
        bus.req1_a = 0;
        bus.req1_b = 0;
        bus.req1_shamt = 0;
        bus.req1_op = 0;
    endtask

    task automatic set0(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        bus.req0_vld = 1;
        bus.req0_op = op;
        bus.req0_a = a;
        bus.req0_b = b;
        bus.req0_shamt = sh;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        bus.rsp_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    logic [2:0]  vop [4] = '{3'b100, 3'b111, 3'b101, 3'b010};
    logic [31:0] va  [4] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    logic [31:0] vb  [4] = '{32'h80000000, 32'h0, 32'h0001ABCD, 32'h1};
    logic [4:0]  vsh [4] = '{5'd4, 5'd0, 5'd0, 5'd0};
    logic [31:0] vex [4] = '{32'hF8000000, 32'h1, 32'hABCD0000, 32'h0};

    initial begin
        rst_n = 0;
        idle();
        bus.rsp_rdy = 0;
        #12;
        bus.req0_vld = 1;
        #1;
        chk("rst_rdy0", {31'd0, bus.req0_rdy}, 32'd0);
        chk("rst_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        chk("rst_count", 32'(bus.rsp_count), 32'd0);
        do_reset();

        // single subtract
        bus.rsp_rdy = 1;
        set0(3'b110, 32'd5, 32'd3, 5'd0);
        #1;
        chk("single_rdy0", {31'd0, bus.req0_rdy}, 32'd1);
        step();
        bus.req0_vld = 0;
        #1;
        chk("single_vld", {31'd0, bus.rsp_vld}, 32'd1);
        chk("single_data", bus.rsp_data, 32'd2);
        chk("single_id", {31'd0, bus.rsp_id}, 32'd0);
        step();
        chk("single_cnt0", 32'(bus.rsp_count), 32'd0);

        // contention alternates grants
        do_reset();
        bus.rsp_rdy = 1;
        set0(3'b010, 32'd1, 32'd1, 5'd0);
        bus.req1_vld = 1;
        bus.req1_op = 3'b011;
        bus.req1_a = 0;
        bus.req1_b = 1;
        bus.req1_shamt = 4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_rdy0", {31'd0, bus.req0_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_rdy1", {31'd0, bus.req1_rdy}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("cont_data", bus.rsp_data, (i % 2 == 1) ? 32'd2 : 32'd16);
                chk("cont_id", {31'd0, bus.rsp_id}, (i % 2 == 1) ? 32'd0 : 32'd1);
            end
            step();
        end
        idle();
        #1;
        chk("cont_last", bus.rsp_data, 32'd16);
        step();

        // backpressure on a full FIFO
        do_reset();
        bus.req1_vld = 1;
        bus.req1_op = 3'b010;
        bus.req1_a = 1;
        bus.req1_b = 2;
        #1;
        chk("bp_rdy_a", {31'd0, bus.req1_rdy}, 32'd1);
        step();
        chk("bp_rdy_b", {31'd0, bus.req1_rdy}, 32'd1);
        step();
        chk("bp_rdy_full", {31'd0, bus.req1_rdy}, 32'd0);
        chk("bp_cnt2", 32'(bus.rsp_count), 32'd2);
        bus.rsp_rdy = 1;
        #1;
        chk("bp_nocredit", {31'd0, bus.req1_rdy}, 32'd0);
        step();
        bus.rsp_rdy = 0;
        #1;
        chk("bp_cnt1", 32'(bus.rsp_count), 32'd1);
        chk("bp_rdy_again", {31'd0, bus.req1_rdy}, 32'd1);
        step();
        bus.req1_vld = 0;
        #1;
        chk("bp_cnt2b", 32'(bus.rsp_count), 32'd2);
        chk("bp_data", bus.rsp_data, 32'd3);
        chk("bp_id", {31'd0, bus.rsp_id}, 32'd1);
        bus.rsp_rdy = 1;
        step();
        step();
        chk("bp_drain", 32'(bus.rsp_count), 32'd0);

        // individual operations
        for (int i = 0; i < 4; i++) begin
            set0(vop[i], va[i], vb[i], vsh[i]);
            step();
            bus.req0_vld = 0;
            #1;
            chk("op_data", bus.rsp_data, vex[i]);
            step();
        end

        // reset in the middle of a run
        bus.rsp_rdy = 0;
        set0(3'b000, 32'hF0, 32'h3C, 5'd0);
        step();
        step();
        bus.req0_vld = 0;
        #1;
        chk("mr_cnt2", 32'(bus.rsp_count), 32'd2);
        #2;
        rst_n = 0;
        #1;
        chk("mr_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("mr_data", bus.rsp_data, 32'd0);
        chk("mr_cnt", 32'(bus.rsp_count), 32'd0);
        step();
        rst_n = 1;
        set0(3'b001, 32'd4, 32'd1, 5'd0);
        step();
        bus.req0_vld = 0;
        #1;
        chk("mr_cnt1", 32'(bus.rsp_count), 32'd1);
        chk("mr_data1", bus.rsp_data, 32'd5);
        bus.rsp_rdy = 1;
        step();

        // push and pop in the same cycle
        bus.rsp_rdy = 0;
        set0(3'b010, 32'd10, 32'd20, 5'd0);
        step();
        bus.rsp_rdy = 1;
        set0(3'b010, 32'd7, 32'd8, 5'd0);
        #1;
        chk("pp_rdy0", {31'd0, bus.req0_rdy}, 32'd1);
        chk("pp_head", bus.rsp_data, 32'd30);
        step();
        bus.req0_vld = 0;
        #1;
        chk("pp_cnt", 32'(bus.rsp_count), 32'd1);
        chk("pp_data", bus.rsp_data, 32'd15);
        step();
        chk("pp_empty", 32'(bus.rsp_count), 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
